// File: rtl/gx4000_pkg.sv
// Shared types and constants for the GX4000 .CPR cartridge loader.
// States, error codes and RIFF magic words are kept here so the loader and its bench agree.
package gx4000_pkg;

    typedef enum logic [3:0] {
        IDLE,
        RIFF_ID,
        RIFF_SZ,
        FORM,
        CK_ID,
        CK_SZ,
        CK_DATA,
        CK_SKIP,
        CK_PAD,
        DONE,
        ERROR
    } cpr_state_t;

    localparam logic [2:0] ERR_NONE  = 3'd0;
    localparam logic [2:0] ERR_RIFF  = 3'd1;
    localparam logic [2:0] ERR_FORM  = 3'd2;
    localparam logic [2:0] ERR_TRUNC = 3'd3;
    localparam logic [2:0] ERR_BANK  = 3'd4;
    localparam logic [2:0] ERR_GAP   = 3'd5;

    // Four-character codes as seen after little-endian collection (first byte in bits 7:0).
    localparam logic [31:0] FOURCC_RIFF = 32'h4646_4952;
    localparam logic [31:0] FOURCC_AMS  = 32'h2153_4D41;
    localparam logic [15:0] FOURCC_CB   = 16'h6263;

    localparam int BANK_BYTES = 16384;

    function automatic logic is_digit(input logic [7:0] c);
        return (c >= 8'h30) && (c <= 8'h39);
    endfunction

    // nn[7:0] is the tens character, nn[15:8] the units character.
    function automatic logic [6:0] cb_number(input logic [15:0] nn);
        return ({3'd0, nn[3:0]} * 7'd10) + {3'd0, nn[11:8]};
    endfunction

endpackage

// File: rtl/gx4000_cpr_loader_if.sv
// Bundles the ioctl download stream, the cartridge write port and the load status.
// The master drives the download; the slave is the loader.
interface gx4000_cpr_loader_if;
    logic        ioctl_download;
    logic [7:0]  ioctl_index;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;

    logic [24:0] cart_addr;
    logic [7:0]  cart_data;
    logic        cart_wr;

    logic        load_busy;
    logic        load_done;
    logic        load_error;
    logic [2:0]  err_code;
    logic [5:0]  bank_count;

    modport master (
        output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
        input  cart_addr, cart_data, cart_wr,
        input  load_busy, load_done, load_error, err_code, bank_count
    );

    modport slave (
        input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
        output cart_addr, cart_data, cart_wr,
        output load_busy, load_done, load_error, err_code, bank_count
    );
endinterface

// File: rtl/gx4000_le32_collect.sv
// Little-endian 32-bit word collector shared by every 4-byte header/ID/size field.
// word_next is the word including the byte being shifted in, so a field can be judged on its 4th byte.
module gx4000_le32_collect (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        shift_en,
    input  logic [7:0]  byte_in,
    output logic [31:0] word_next,
    output logic        full,
    output logic [1:0]  count
);

    logic [31:0] shreg_q, shreg_d;
    logic [1:0]  cnt_q, cnt_d;

    assign word_next = {byte_in, shreg_q[31:8]};
    assign full      = shift_en && (cnt_q == 2'd3);
    assign count     = cnt_q;

    always_comb begin
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        if (clear) begin
            shreg_d = 32'd0;
            cnt_d   = 2'd0;
        end else if (shift_en) begin
            shreg_d = word_next;
            cnt_d   = cnt_q + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shreg_q <= 32'd0;
            cnt_q   <= 2'd0;
        end else begin
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/gx4000_cpr_loader.sv
// Parses a RIFF "AMS!" cartridge image streamed over ioctl and writes its cbNN chunks
// into SDRAM as 16 KB banks, reporting done/error status and the number of banks seen.
module gx4000_cpr_loader
    import gx4000_pkg::*;
#(
    parameter logic [7:0]  CART_INDEX = 8'd3,
    parameter logic [24:0] BASE_ADDR  = 25'h0100000,
    parameter int          MAX_BANKS  = 32
) (
    input  logic               clk_sys,
    input  logic               reset,
    gx4000_cpr_loader_if.slave bus
);

    localparam logic [6:0] MAX_BANKS_W = 7'(MAX_BANKS);

    cpr_state_t  state_q, state_d;
    logic        dl_prev_q;
    logic [24:0] byte_cnt_q, byte_cnt_d;
    logic [4:0]  bank_q, bank_d;
    logic        is_bank_q, is_bank_d;
    logic [14:0] offset_q, offset_d;
    logic [31:0] remaining_q, remaining_d;
    logic        pad_q, pad_d;
    logic [24:0] cart_addr_q, cart_addr_d;
    logic [7:0]  cart_data_q, cart_data_d;
    logic        cart_wr_q, cart_wr_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        error_q, error_d;
    logic [2:0]  err_code_q, err_code_d;
    logic [5:0]  bank_count_q, bank_count_d;

    logic        start, fall, active, accept, addr_ok, collect_en;
    logic [31:0] word_next;
    logic        word_full;
    logic [1:0]  id_count;
    logic [6:0]  ck_num;
    logic        ck_valid;
    logic [5:0]  bank_plus1;
    cpr_state_t  after_chunk;
    logic        raise;
    logic [2:0]  raise_code;

    // A start edge wins over a same-cycle strobe, so that byte is never parsed.
    assign start   = bus.ioctl_download && !dl_prev_q && (bus.ioctl_index == CART_INDEX);
    assign fall    = !bus.ioctl_download && dl_prev_q;
    assign active  = !(state_q inside {IDLE, DONE, ERROR});
    assign accept  = active && bus.ioctl_wr && bus.ioctl_download && !start;
    assign addr_ok = (bus.ioctl_addr == byte_cnt_q);
    assign collect_en = accept && addr_ok && (state_q inside {RIFF_ID, RIFF_SZ, FORM, CK_ID, CK_SZ});

    assign ck_num      = cb_number(word_next[31:16]);
    assign ck_valid    = is_digit(word_next[23:16]) && is_digit(word_next[31:24]) && (ck_num < MAX_BANKS_W);
    assign bank_plus1  = {1'b0, bank_q} + 6'd1;
    assign after_chunk = pad_q ? CK_PAD : CK_ID;

    gx4000_le32_collect u_collect (
        .clk       (clk_sys),
        .reset     (reset),
        .clear     (start),
        .shift_en  (collect_en),
        .byte_in   (bus.ioctl_dout),
        .word_next (word_next),
        .full      (word_full),
        .count     (id_count)
    );

    always_comb begin
        state_d      = state_q;
        byte_cnt_d   = byte_cnt_q;
        bank_d       = bank_q;
        is_bank_d    = is_bank_q;
        offset_d     = offset_q;
        remaining_d  = remaining_q;
        pad_d        = pad_q;
        cart_addr_d  = cart_addr_q;
        cart_data_d  = cart_data_q;
        cart_wr_d    = 1'b0;
        busy_d       = busy_q;
        done_d       = done_q;
        error_d      = error_q;
        err_code_d   = err_code_q;
        bank_count_d = bank_count_q;
        raise        = 1'b0;
        raise_code   = ERR_NONE;

        if (start) begin
            state_d      = RIFF_ID;
            byte_cnt_d   = 25'd0;
            busy_d       = 1'b1;
            done_d       = 1'b0;
            error_d      = 1'b0;
            err_code_d   = ERR_NONE;
            bank_count_d = 6'd0;
        end else if (fall && active) begin
            busy_d = 1'b0;
            if (state_q == CK_ID && id_count == 2'd0) begin
                state_d = DONE;
                done_d  = 1'b1;
            end else begin
                raise      = 1'b1;
                raise_code = ERR_TRUNC;
            end
        end else if (accept) begin
            if (!addr_ok) begin
                raise      = 1'b1;
                raise_code = ERR_GAP;
            end else begin
                byte_cnt_d = byte_cnt_q + 25'd1;
                case (state_q)
                    RIFF_ID: if (word_full) begin
                        if (word_next == FOURCC_RIFF) state_d = RIFF_SZ;
                        else begin
                            raise      = 1'b1;
                            raise_code = ERR_RIFF;
                        end
                    end
                    RIFF_SZ: if (word_full) state_d = FORM;
                    FORM: if (word_full) begin
                        if (word_next == FOURCC_AMS) state_d = CK_ID;
                        else begin
                            raise      = 1'b1;
                            raise_code = ERR_FORM;
                        end
                    end
                    CK_ID: if (word_full) begin
                        if (word_next[15:0] != FOURCC_CB) begin
                            is_bank_d = 1'b0;
                            state_d   = CK_SZ;
                        end else if (ck_valid) begin
                            is_bank_d = 1'b1;
                            bank_d    = ck_num[4:0];
                            state_d   = CK_SZ;
                        end else begin
                            raise      = 1'b1;
                            raise_code = ERR_BANK;
                        end
                    end
                    CK_SZ: if (word_full) begin
                        remaining_d = word_next;
                        pad_d       = word_next[0];
                        offset_d    = 15'd0;
                        if (word_next == 32'd0) state_d = CK_ID;
                        else state_d = is_bank_q ? CK_DATA : CK_SKIP;
                    end
                    CK_DATA: begin
                        // Offset saturates at one bank; bytes beyond it are consumed silently.
                        if (!offset_q[14]) begin
                            cart_wr_d   = 1'b1;
                            cart_addr_d = BASE_ADDR + {6'd0, bank_q, offset_q[13:0]};
                            cart_data_d = bus.ioctl_dout;
                            offset_d    = offset_q + 15'd1;
                        end
                        if (offset_q == 15'd0 && bank_plus1 > bank_count_q) bank_count_d = bank_plus1;
                        remaining_d = remaining_q - 32'd1;
                        if (remaining_q == 32'd1) state_d = after_chunk;
                    end
                    CK_SKIP: begin
                        remaining_d = remaining_q - 32'd1;
                        if (remaining_q == 32'd1) state_d = after_chunk;
                    end
                    CK_PAD: state_d = CK_ID;
                    default: ;
                endcase
            end
        end

        if (raise) begin
            state_d    = ERROR;
            error_d    = 1'b1;
            err_code_d = raise_code;
            busy_d     = 1'b0;
        end
    end

    // dl_prev_q follows the pin even in reset so a download held across reset never looks like a new start.
    always_ff @(posedge clk_sys) begin
        dl_prev_q <= bus.ioctl_download;
        if (reset) begin
            state_q      <= IDLE;
            byte_cnt_q   <= 25'd0;
            bank_q       <= 5'd0;
            is_bank_q    <= 1'b0;
            offset_q     <= 15'd0;
            remaining_q  <= 32'd0;
            pad_q        <= 1'b0;
            cart_addr_q  <= 25'd0;
            cart_data_q  <= 8'd0;
            cart_wr_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            err_code_q   <= ERR_NONE;
            bank_count_q <= 6'd0;
        end else begin
            state_q      <= state_d;
            byte_cnt_q   <= byte_cnt_d;
            bank_q       <= bank_d;
            is_bank_q    <= is_bank_d;
            offset_q     <= offset_d;
            remaining_q  <= remaining_d;
            pad_q        <= pad_d;
            cart_addr_q  <= cart_addr_d;
            cart_data_q  <= cart_data_d;
            cart_wr_q    <= cart_wr_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
            err_code_q   <= err_code_d;
            bank_count_q <= bank_count_d;
        end
    end

    assign bus.cart_addr  = cart_addr_q;
    assign bus.cart_data  = cart_data_q;
    assign bus.cart_wr    = cart_wr_q;
    assign bus.load_busy  = busy_q;
    assign bus.load_done  = done_q;
    assign bus.load_error = error_q;
    assign bus.err_code   = err_code_q;
    assign bus.bank_count = bank_count_q;

endmodule

// File: tb/tb_gx4000_cpr_loader.sv
// Bench for gx4000_cpr_loader: table of small CPR files plus hand-built multi-bank,
// skip, oversize, address-gap and reset sequences; cart writes are checked against a scoreboard.
module tb_gx4000_cpr_loader;

    logic clk_sys = 1'b0;
    logic reset   = 1'b1;
    always #5 clk_sys = ~clk_sys;

    gx4000_cpr_loader_if bus ();

    gx4000_cpr_loader dut (
        .clk_sys (clk_sys),
        .reset   (reset),
        .bus     (bus)
    );

    typedef struct {
        logic [7:0]  data;
        bit          wr;
        logic [24:0] addr;
    } sbyte_t;

    typedef struct {
        logic [24:0] addr;
        logic [7:0]  data;
        int          due;
    } exp_t;

    typedef struct {
        string       name;
        logic [31:0] riff;
        logic [31:0] form;
        logic [31:0] ckid;
        logic [31:0] cksz;
        int          n_send;
        int          bank;
        int          n_write;
        logic [7:0]  index;
        bit          exp_done;
        logic [2:0]  exp_code;
        logic [5:0]  exp_bc;
    } vec_t;

    sbyte_t      stream[$];
    exp_t        sb[$];
    exp_t        mon_e;
    vec_t        vecs[10];
    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    logic [24:0] last_wr_addr = 25'd0;

    always @(posedge clk_sys) cyc <= cyc + 1;

    // Every cart_wr must match the oldest expected write, arriving exactly one cycle after its byte.
    always @(negedge clk_sys) begin
        if (bus.cart_wr === 1'b1) begin
            checks++;
            last_wr_addr = bus.cart_addr;
            if (sb.size() == 0) begin
                failures++;
                $display("[TB] FAIL cart_wr_unexpected: got addr=%h data=%h at cycle %0d, expected no write",
                         bus.cart_addr, bus.cart_data, cyc);
            end else begin
                mon_e = sb.pop_front();
                if (bus.cart_addr !== mon_e.addr || bus.cart_data !== mon_e.data || cyc != mon_e.due) begin
                    failures++;
                    $display("[TB] FAIL cart_write: got addr=%h data=%h cycle=%0d, expected addr=%h data=%h cycle=%0d",
                             bus.cart_addr, bus.cart_data, cyc, mon_e.addr, mon_e.data, mon_e.due);
                end
            end
        end else if (sb.size() > 0 && sb[0].due <= cyc) begin
            checks++;
            failures++;
            mon_e = sb.pop_front();
            $display("[TB] FAIL cart_write_missing: got no write at cycle %0d, expected addr=%h data=%h",
                     cyc, mon_e.addr, mon_e.data);
        end
    end

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    function automatic logic [31:0] fourcc(input string s);
        return {s[3], s[2], s[1], s[0]};
    endfunction

    function automatic logic [31:0] cb_id(input int n);
        return {8'(8'h30 + n % 10), 8'(8'h30 + n / 10), 8'h62, 8'h63};
    endfunction

    function automatic logic [7:0] pat(input int bank, input int i);
        return 8'((i + 1) * 17 + bank * 3);
    endfunction

    task automatic push_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) stream.push_back('{data: w[8*i +: 8], wr: 1'b0, addr: 25'd0});
    endtask

    task automatic push_header();
        push_word(fourcc("RIFF"));
        push_word(32'h0);
        push_word(fourcc("AMS!"));
    endtask

    task automatic push_chunk_data(input int bank, input int n_send, input int n_write);
        for (int i = 0; i < n_send; i++)
            stream.push_back('{data: pat(bank, i), wr: (i < n_write),
                               addr: 25'(32'h0100000 + bank * 16384 + i)});
    endtask

    task automatic send_bytes(input int start_addr, input int gap_at);
        for (int i = 0; i < stream.size(); i++) begin
            bus.ioctl_wr   = 1'b1;
            bus.ioctl_addr = 25'(start_addr + i + ((gap_at >= 0 && i >= gap_at) ? 1 : 0));
            bus.ioctl_dout = stream[i].data;
            if (stream[i].wr) sb.push_back('{addr: stream[i].addr, data: stream[i].data, due: cyc + 1});
            @(negedge clk_sys);
        end
        bus.ioctl_wr = 1'b0;
    endtask

    task automatic apply_stimulus(input string name, input logic [7:0] index, input bit drop, input int gap_at);
        @(negedge clk_sys);
        bus.ioctl_index    = index;
        bus.ioctl_download = 1'b1;
        @(negedge clk_sys);
        check_output({name, ".busy_at_start"}, 32'(bus.load_busy), 32'(index == 8'd3));
        send_bytes(0, gap_at);
        if (drop) bus.ioctl_download = 1'b0;
        repeat (3) @(negedge clk_sys);
        stream.delete();
    endtask

    task automatic check_status(input string name, input bit done, input logic [2:0] code, input logic [5:0] bc);
        check_output({name, ".busy"},       32'(bus.load_busy),  32'd0);
        check_output({name, ".done"},       32'(bus.load_done),  32'(done));
        check_output({name, ".error"},      32'(bus.load_error), 32'(code != 3'd0));
        check_output({name, ".err_code"},   32'(bus.err_code),   32'(code));
        check_output({name, ".bank_count"}, 32'(bus.bank_count), 32'(bc));
    endtask

    initial begin
        vecs[0] = '{name: "minimal", riff: fourcc("RIFF"), form: fourcc("AMS!"), ckid: cb_id(0), cksz: 32'd4,
                    n_send: 4, bank: 0, n_write: 4, index: 8'd3, exp_done: 1'b1, exp_code: 3'd0, exp_bc: 6'd1};
        vecs[1] = '{name: "bad_riff", riff: fourcc("RIFX"), form: fourcc("AMS!"), ckid: cb_id(0), cksz: 32'd4,
                    n_send: 4, bank: 0, n_write: 0, index: 8'd3, exp_done: 1'b0, exp_code: 3'd1, exp_bc: 6'd0};
        vecs[2] = '{name: "bad_form", riff: fourcc("RIFF"), form: fourcc("AMS?"), ckid: cb_id(0), cksz: 32'd4,
                    n_send: 4, bank: 0, n_write: 0, index: 8'd3, exp_done: 1'b0, exp_code: 3'd2, exp_bc: 6'd0};
        vecs[3] = '{name: "bank_32", riff: fourcc("RIFF"), form: fourcc("AMS!"), ckid: cb_id(32), cksz: 32'd4,
                    n_send: 4, bank: 0, n_write: 0, index: 8'd3, exp_done: 1'b0, exp_code: 3'd4, exp_bc: 6'd0};
        vecs[4] = '{name: "bank_nondigit", riff: fourcc("RIFF"), form: fourcc("AMS!"), ckid: fourcc("cbA1"), cksz: 32'd4,
                    n_send: 4, bank: 0, n_write: 0, index: 8'd3, exp_done: 1'b0, exp_code: 3'd4, exp_bc: 6'd0};
        vecs[5] = '{name: "odd_pad_cb04", riff: fourcc("RIFF"), form: fourcc("AMS!"), ckid: cb_id(4), cksz: 32'd3,
                    n_send: 4, bank: 4, n_write: 3, index: 8'd3, exp_done: 1'b1, exp_code: 3'd0, exp_bc: 6'd5};
        vecs[6] = '{name: "truncated", riff: fourcc("RIFF"), form: fourcc("AMS!"), ckid: cb_id(3), cksz: 32'd8,
                    n_send: 4, bank: 3, n_write: 4, index: 8'd3, exp_done: 1'b0, exp_code: 3'd3, exp_bc: 6'd4};
        vecs[7] = '{name: "other_index", riff: fourcc("RIFF"), form: fourcc("AMS!"), ckid: cb_id(0), cksz: 32'd4,
                    n_send: 4, bank: 0, n_write: 0, index: 8'd1, exp_done: 1'b0, exp_code: 3'd3, exp_bc: 6'd4};
        vecs[8] = '{name: "bank_31", riff: fourcc("RIFF"), form: fourcc("AMS!"), ckid: cb_id(31), cksz: 32'd2,
                    n_send: 2, bank: 31, n_write: 2, index: 8'd3, exp_done: 1'b1, exp_code: 3'd0, exp_bc: 6'd32};
        vecs[9] = '{name: "empty_cb07", riff: fourcc("RIFF"), form: fourcc("AMS!"), ckid: cb_id(7), cksz: 32'd0,
                    n_send: 0, bank: 7, n_write: 0, index: 8'd3, exp_done: 1'b1, exp_code: 3'd0, exp_bc: 6'd0};

        bus.ioctl_download = 1'b0;
        bus.ioctl_index    = 8'd0;
        bus.ioctl_wr       = 1'b0;
        bus.ioctl_addr     = 25'd0;
        bus.ioctl_dout     = 8'd0;
        repeat (3) @(negedge clk_sys);
        check_status("reset", 1'b0, 3'd0, 6'd0);
        check_output("reset.cart_wr", 32'(bus.cart_wr), 32'd0);
        reset = 1'b0;
        @(negedge clk_sys);

        for (int v = 0; v < 10; v++) begin
            push_word(vecs[v].riff);
            push_word(32'h0);
            push_word(vecs[v].form);
            push_word(vecs[v].ckid);
            push_word(vecs[v].cksz);
            push_chunk_data(vecs[v].bank, vecs[v].n_send, vecs[v].n_write);
            apply_stimulus(vecs[v].name, vecs[v].index, 1'b1, -1);
            check_status(vecs[v].name, vecs[v].exp_done, vecs[v].exp_code, vecs[v].exp_bc);
        end

        push_header();
        push_word(cb_id(1)); push_word(32'd16384); push_chunk_data(1, 16384, 16384);
        push_word(cb_id(5)); push_word(32'd16384); push_chunk_data(5, 16384, 16384);
        apply_stimulus("two_banks", 8'd3, 1'b1, -1);
        check_status("two_banks", 1'b1, 3'd0, 6'd6);
        check_output("two_banks.last_addr", 32'(last_wr_addr), 32'h0117FFF);
        check_output("two_banks.addr_hold", 32'(bus.cart_addr), 32'h0117FFF);

        push_header();
        push_word(fourcc("INFO")); push_word(32'd3); push_chunk_data(0, 4, 0);
        push_word(cb_id(0)); push_word(32'd2); push_chunk_data(0, 2, 2);
        apply_stimulus("skip_info", 8'd3, 1'b1, -1);
        check_status("skip_info", 1'b1, 3'd0, 6'd1);

        push_header();
        push_word(cb_id(2)); push_word(32'd16386); push_chunk_data(2, 16386, 16384);
        apply_stimulus("oversize_cb02", 8'd3, 1'b1, -1);
        check_status("oversize_cb02", 1'b1, 3'd0, 6'd3);

        push_header();
        push_word(cb_id(0)); push_word(32'd4); push_chunk_data(0, 4, 2);
        apply_stimulus("addr_gap", 8'd3, 1'b1, 22);
        check_status("addr_gap", 1'b0, 3'd5, 6'd1);

        push_header();
        push_word(cb_id(0)); push_word(32'd4); push_chunk_data(0, 2, 2);
        apply_stimulus("mid_reset", 8'd3, 1'b0, -1);
        check_output("mid_reset.busy_before", 32'(bus.load_busy), 32'd1);
        reset = 1'b1;
        repeat (2) @(negedge clk_sys);
        reset = 1'b0;
        check_status("mid_reset.after", 1'b0, 3'd0, 6'd0);
        check_output("mid_reset.cart_addr", 32'(bus.cart_addr), 32'd0);
        check_output("mid_reset.cart_data", 32'(bus.cart_data), 32'd0);
        push_chunk_data(0, 2, 0);
        send_bytes(22, -1);
        stream.delete();
        bus.ioctl_download = 1'b0;
        repeat (3) @(negedge clk_sys);
        check_status("mid_reset.ignored", 1'b0, 3'd0, 6'd0);

        check_output("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
